// File: rtl/keypoint_pkg.sv
// Shared widths and the keypoint record type for the keypoint queue and its users.
package keypoint_pkg;

  localparam int ANG_W_D   = 12;
  localparam int COOR_W_D  = 10;
  localparam int SCORE_W_D = 8;
  localparam int DEPTH_W_D = 16;

  typedef struct packed {
    logic [ANG_W_D-1:0]   sin;
    logic [ANG_W_D-1:0]   cos;
    logic [COOR_W_D-1:0]  coor_x;
    logic [COOR_W_D-1:0]  coor_y;
    logic [SCORE_W_D-1:0] score;
    logic [DEPTH_W_D-1:0] depth;
  } keypoint_t;

  function automatic int kp_entry_w(input int ang_w, input int coor_w,
                                    input int score_w, input int depth_w);
    return 2 * ang_w + 2 * coor_w + score_w + depth_w;
  endfunction

endpackage

// File: rtl/keypoint_queue_if.sv
// Producer/consumer bundle of the keypoint queue; master drives the i_* side.
interface keypoint_queue_if
  import keypoint_pkg::*;
#(
  parameter int ANG_W   = ANG_W_D,
  parameter int COOR_W  = COOR_W_D,
  parameter int SCORE_W = SCORE_W_D,
  parameter int DEPTH_W = DEPTH_W_D,
  parameter int CNT_W   = 7
);
  logic               i_flush;
  logic               i_push;
  logic [ANG_W-1:0]   i_sin;
  logic [ANG_W-1:0]   i_cos;
  logic [COOR_W-1:0]  i_coor_x;
  logic [COOR_W-1:0]  i_coor_y;
  logic [SCORE_W-1:0] i_score;
  logic [DEPTH_W-1:0] i_depth;
  logic               i_pop;
  logic               o_valid;
  logic [ANG_W-1:0]   o_sin;
  logic [ANG_W-1:0]   o_cos;
  logic [COOR_W-1:0]  o_coor_x;
  logic [COOR_W-1:0]  o_coor_y;
  logic [SCORE_W-1:0] o_score;
  logic [DEPTH_W-1:0] o_depth;
  logic [CNT_W-1:0]   o_count;
  logic               o_full;
  logic               o_drop;

  modport master (
    output i_flush, i_push, i_sin, i_cos, i_coor_x, i_coor_y, i_score, i_depth, i_pop,
    input  o_valid, o_sin, o_cos, o_coor_x, o_coor_y, o_score, o_depth, o_count, o_full, o_drop
  );

  modport slave (
    input  i_flush, i_push, i_sin, i_cos, i_coor_x, i_coor_y, i_score, i_depth, i_pop,
    output o_valid, o_sin, o_cos, o_coor_x, o_coor_y, o_score, o_depth, o_count, o_full, o_drop
  );
endinterface

// File: rtl/keyq_min_score.sv
// Combinational argmin tree over N packed scores; ties resolve to the lowest index.
module keyq_min_score #(
  parameter int N       = 64,
  parameter int SCORE_W = 8,
  parameter int IDX_W   = 6
) (
  input  logic [N*SCORE_W-1:0] scores,
  output logic [IDX_W-1:0]     min_idx,
  output logic [SCORE_W-1:0]   min_score
);
  localparam int LVL = $clog2(N);
  localparam int P   = 1 << LVL;

  // Heap layout: node k has children 2k+1 and 2k+2, leaves start at P-1.
  logic [SCORE_W-1:0] node_score [2*P-1];
  logic [IDX_W-1:0]   node_idx   [2*P-1];

  genvar gi;
  generate
    for (gi = 0; gi < P; gi++) begin : g_leaf
      if (gi < N) begin : g_real
        assign node_score[P-1+gi] = scores[gi*SCORE_W +: SCORE_W];
      end else begin : g_pad
        // Padding never beats a real entry: equal scores favour the left (lower) side.
        assign node_score[P-1+gi] = '1;
      end
      assign node_idx[P-1+gi] = IDX_W'(gi);
    end

    for (gi = 0; gi < P-1; gi++) begin : g_node
      logic take_right;
      assign take_right      = node_score[2*gi+2] < node_score[2*gi+1];
      assign node_score[gi]  = take_right ? node_score[2*gi+2] : node_score[2*gi+1];
      assign node_idx[gi]    = take_right ? node_idx[2*gi+2]   : node_idx[2*gi+1];
    end
  endgenerate

  assign min_idx   = node_idx[0];
  assign min_score = node_score[0];
endmodule

// File: rtl/keypoint_queue.sv
// Circular FIFO of ORB keypoint records with explicit pointers, flush and overflow drop.
// Build option KEYQ_SCORE_REPLACE_EN: a push into a full queue may evict the lowest-score entry.
module keypoint_queue
  import keypoint_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int ANG_W   = ANG_W_D,
  parameter int COOR_W  = COOR_W_D,
  parameter int SCORE_W = SCORE_W_D,
  parameter int DEPTH_W = DEPTH_W_D
) (
  input logic             i_clk,
  input logic             i_rst_n,
  keypoint_queue_if.slave kq
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = kp_entry_w(ANG_W, COOR_W, SCORE_W, DEPTH_W);
  localparam int SC_LO   = DEPTH_W;
  localparam int Y_LO    = SC_LO + SCORE_W;
  localparam int X_LO    = Y_LO + COOR_W;
  localparam int COS_LO  = X_LO + COOR_W;
  localparam int SIN_LO  = COS_LO + ANG_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ENTRY_W-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               drop_reg, drop_next;
  logic               wr_en;
  logic [PTR_W-1:0]   wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] head;
  logic               valid, is_full, do_pop, push_acc, overflow;
  logic               replace_ok;
  logic [PTR_W-1:0]   replace_idx;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign wr_data = {kq.i_sin, kq.i_cos, kq.i_coor_x, kq.i_coor_y, kq.i_score, kq.i_depth};

`ifdef KEYQ_SCORE_REPLACE_EN
  logic [DEPTH*SCORE_W-1:0] score_flat;
  logic [SCORE_W-1:0]       min_score;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_score
      assign score_flat[gi*SCORE_W +: SCORE_W] = mem_reg[gi][SC_LO +: SCORE_W];
    end
  endgenerate

  keyq_min_score #(
    .N       (DEPTH),
    .SCORE_W (SCORE_W),
    .IDX_W   (PTR_W)
  ) u_min_score (
    .scores    (score_flat),
    .min_idx   (replace_idx),
    .min_score (min_score)
  );

  assign replace_ok = kq.i_score > min_score;
`else
  assign replace_ok  = 1'b0;
  assign replace_idx = wr_ptr_reg;
`endif

  assign valid    = count_reg != '0;
  assign is_full  = count_reg == FULL_CNT;
  assign do_pop   = kq.i_pop && valid;
  // A pop in the same cycle frees a slot, so only a full queue without pop overflows.
  assign overflow = kq.i_push && is_full && !do_pop;
  assign push_acc = kq.i_push && !overflow;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    drop_next   = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = wr_ptr_reg;
    if (!kq.i_flush) begin
      if (push_acc) begin
        wr_en       = 1'b1;
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end else if (overflow && replace_ok) begin
        wr_en   = 1'b1;
        wr_addr = replace_idx;
      end
      drop_next = overflow && !replace_ok;
      if (do_pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      if (push_acc && !do_pop) begin
        count_next = count_reg + 1'b1;
      end else if (!push_acc && do_pop) begin
        count_next = count_reg - 1'b1;
      end
    end else begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      drop_reg   <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_reg[wr_addr] <= wr_data;
      end
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      drop_reg   <= drop_next;
    end
  end

  // Head reads 0 while empty, so stale storage never shows after a flush.
  assign head        = valid ? mem_reg[rd_ptr_reg] : '0;
  assign kq.o_valid  = valid;
  assign kq.o_sin    = head[SIN_LO +: ANG_W];
  assign kq.o_cos    = head[COS_LO +: ANG_W];
  assign kq.o_coor_x = head[X_LO +: COOR_W];
  assign kq.o_coor_y = head[Y_LO +: COOR_W];
  assign kq.o_score  = head[SC_LO +: SCORE_W];
  assign kq.o_depth  = head[0 +: DEPTH_W];
  assign kq.o_count  = count_reg;
  assign kq.o_full   = is_full;
  assign kq.o_drop   = drop_reg;
endmodule
